vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
- REQ-002 Parameter H_FP, default 16, horizontal front porch (dot clocks).
- REQ-003 Parameter H_SYNC, default 96, hsync pulse width.
- REQ-004 Parameter H_BP, default 48, horizontal back porch.
- REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
- REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
- REQ-007 Parameter V_SYNC, default 2, vsync pulse width (lines).
- REQ-008 Parameter V_BP, default 33, vertical back porch.
- REQ-009 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
- REQ-010 Port dotclock  input  1  pixel clock; the only clock.
- REQ-011 Port rst_n  input  1  reset; asynchronous, active-low.
- REQ-012 Port en  input  1  count enable; low freezes all state.
- REQ-013 Port hsync  output  1  horizontal sync at SYNC_POL during the sync interval.
- REQ-014 Port vsync  output  1  vertical sync at SYNC_POL during the sync interval.
- REQ-015 Port de  output  1  display enable; high for visible pixels.
- REQ-016 Port pix_x  output  10  current horizontal count.
- REQ-017 Port pix_y  output  10  current vertical count.
- REQ-018 Port line_start  output  1  one-cycle pulse when pix_x == 0.
- REQ-019 Port frame_start  output  1  one-cycle pulse when pix_x == 0 and pix_y == 0.

Function
- REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525) shall be derived constants.
- REQ-021 On each dotclock rising edge with en high, pix_x shall increment, wrapping H_TOTAL-1 -> 0.
- REQ-022 pix_y shall increment only on a cycle where pix_x wraps, and shall wrap V_TOTAL-1 -> 0.
- REQ-023 With en low, all outputs shall hold their values, with no pulse repeated or lost; resumption continues from the held count.
- REQ-024 All outputs shall be registered and mutually aligned: hsync, vsync, de and the pulses describe the pix_x/pix_y values presented in the same cycle (zero relative latency).
- REQ-025 hsync shall be active iff H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC (656..751).
- REQ-026 vsync shall be active iff V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC (490..491), independent of pix_x.
- REQ-027 de shall be high iff pix_x < H_ACTIVE and pix_y < V_ACTIVE.
- REQ-028 line_start and frame_start shall be high for exactly one enabled cycle per line or frame.
- REQ-029 Counter arithmetic shall be 10-bit unsigned; a count shall never exceed TOTAL-1.
- REQ-030 Decoding shall use next-state counter values so that alignment (REQ-024) holds at every wrap boundary.

Reset
- REQ-031 Asserting rst_n low shall immediately force pix_x = H_TOTAL-1 and pix_y = V_TOTAL-1, sync outputs inactive (!SYNC_POL), and de, line_start and frame_start = 0.
- REQ-032 The first enabled edge after rst_n deasserts shall produce pix_x = 0, pix_y = 0, de = 1, line_start = 1 and frame_start = 1.
- REQ-033 Reset asserted mid-frame shall abort the frame with no partial sync pulse extended past the reset.

Structure
- REQ-034 Timing defaults, derived totals and sync-window bounds shall reside in the shared package vga_timing_pkg for reuse by the pixel generators.
- REQ-035 One sub-module, mod_counter (parameterised modulus, enable, wrap output), shall be instantiated twice: horizontal and vertical, with the vertical enable = en AND horizontal wrap.

Verification
- REQ-036 Release reset with en = 1 -> first cycle shows pix_x = 0, pix_y = 0, de = 1, frame_start = 1; hsync and vsync high.
- REQ-037 Run one line -> hsync low for exactly 96 cycles starting at pix_x = 656; de high for exactly 640 cycles; line period 800.
- REQ-038 Run two full frames -> frame_start period 420000 cycles; vsync low for 1600 cycles starting at pix_y = 490, pix_x = 0.
- REQ-039 Drop en for 7 cycles at pix_x = 799, pix_y = 524 -> outputs frozen; on resume the next cycle is 0,0 with a single frame_start pulse.
- REQ-040 Assert rst_n asynchronously at pix_x = 700 (hsync low) -> hsync returns high without a clock edge; restart follows REQ-032.
- REQ-041 Override the parameters to 8/1/2/1 x 4/1/1/1 -> hsync window 9..10, vsync window 5, totals 12 x 7; all wraps are correct.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals and sync-window helpers.
// Imported by the timing generator and by any pixel generator that needs the same bounds.
package vga_timing_pkg;

  localparam int unsigned CntWidth = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF      = total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF      = total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vga_ctrl_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input logic [CntWidth-1:0] v,
                                     input logic [CntWidth-1:0] lo,
                                     input logic [CntWidth-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo-N counter. Resets to Modulus-1 so the first enabled edge lands on 0,
// and exposes its next-state value so consumers can register decodes aligned with the count.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Width   = CntWidth,
  parameter int unsigned Modulus = H_TOTAL_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_d_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == Last) ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Last;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign wrap_o    = en_i && (count_q == Last);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered sync, display-enable
// and start pulses, all decoded from next-state counts so they align with pix_x/pix_y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic                dotclock,
  input  logic                rst_n,
  input  logic                en,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [CntWidth-1:0] pix_x,
  output logic [CntWidth-1:0] pix_y,
  output logic                line_start,
  output logic                frame_start
);

  localparam int unsigned HTotal = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CntWidth-1:0] HActive    = CntWidth'(H_ACTIVE);
  localparam logic [CntWidth-1:0] HSyncStart = CntWidth'(H_ACTIVE + H_FP);
  localparam logic [CntWidth-1:0] HSyncEnd   = CntWidth'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntWidth-1:0] VActive    = CntWidth'(V_ACTIVE);
  localparam logic [CntWidth-1:0] VSyncStart = CntWidth'(V_ACTIVE + V_FP);
  localparam logic [CntWidth-1:0] VSyncEnd   = CntWidth'(V_ACTIVE + V_FP + V_SYNC);

  logic [CntWidth-1:0] x_d, y_d;
  logic                h_wrap, v_en, v_wrap_unused;
  vga_ctrl_t           ctrl_q, ctrl_d;

  assign v_en = en & h_wrap;

  mod_counter #(
    .Width  (CntWidth),
    .Modulus(HTotal)
  ) u_h_cnt (
    .clk_i    (dotclock),
    .rst_ni   (rst_n),
    .en_i     (en),
    .count_o  (pix_x),
    .count_d_o(x_d),
    .wrap_o   (h_wrap)
  );

  mod_counter #(
    .Width  (CntWidth),
    .Modulus(VTotal)
  ) u_v_cnt (
    .clk_i    (dotclock),
    .rst_ni   (rst_n),
    .en_i     (v_en),
    .count_o  (pix_y),
    .count_d_o(y_d),
    .wrap_o   (v_wrap_unused)
  );

  // Decode from next-state counts; holding when en is low keeps pulses from repeating.
  always_comb begin
    ctrl_d = ctrl_q;
    if (en) begin
      ctrl_d.hsync       = in_window(x_d, HSyncStart, HSyncEnd) ? SYNC_POL : ~SYNC_POL;
      ctrl_d.vsync       = in_window(y_d, VSyncStart, VSyncEnd) ? SYNC_POL : ~SYNC_POL;
      ctrl_d.de          = (x_d < HActive) && (y_d < VActive);
      ctrl_d.line_start  = (x_d == '0);
      ctrl_d.frame_start = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge dotclock or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q.hsync       <= ~SYNC_POL;
      ctrl_q.vsync       <= ~SYNC_POL;
      ctrl_q.de          <= 1'b0;
      ctrl_q.line_start  <= 1'b0;
      ctrl_q.frame_start <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign hsync       = ctrl_q.hsync;
  assign vsync       = ctrl_q.vsync;
  assign de          = ctrl_q.de;
  assign line_start  = ctrl_q.line_start;
  assign frame_start = ctrl_q.frame_start;

endmodule
